div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Issue/fixup stage directly upstream of the iterative `divider`.
- Accepts RISC-V M-extension divide requests (DIV, DIVU, REM, REMU) over a valid/ready handshake.
- For signed ops, converts operands to magnitudes, drives the unsigned divider with a one-cycle enable pulse, waits for `division_finished`, applies sign correction, and returns one tagged 32-bit result.
- Resolves divide-by-zero and signed overflow itself, without invoking the divider.

Parameters:
- DATA_WIDTH, 32, operand/result width; also the `size` passed to the divider.
- TAG_WIDTH, 5, width of the destination tag carried alongside the request.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_i  in  DATA_WIDTH  dividend.
- rs2_i  in  DATA_WIDTH  divisor.
- tag_i  in  TAG_WIDTH  request tag.
- flush_i  in  1  kill the in-flight request.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- res_data_o  out  DATA_WIDTH  result.
- res_tag_o  out  TAG_WIDTH  tag of the result.
- dividend_o  out  DATA_WIDTH  unsigned magnitude sent to the divider.
- divisor_o  out  DATA_WIDTH  unsigned magnitude sent to the divider.
- div_enable_o  out  1  one-cycle start pulse.
- division_finished_i  in  1  divider completion strobe.
- div_result_i  in  2*DATA_WIDTH  {remainder, quotient} from the divider.

Behaviour:
- Reset values: all outputs 0 except req_ready_o = 1; FSM in IDLE.
- Reset is asynchronous and may arrive mid-operation; it aborts immediately.
- FSM states: IDLE, ISSUE, WAIT, FIXUP, DONE.
- IDLE:
  - A request is accepted when req_valid_i && req_ready_o (cycle N).
  - Register op, tag, operands, sign flags, and magnitudes.
  - Divisor == 0: go to DONE.
  - Signed op with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: go to DONE.
  - Otherwise: go to ISSUE.
- ISSUE (N+1):
  - div_enable_o = 1 for exactly this cycle.
  - dividend_o/divisor_o hold the magnitudes from ISSUE until leaving WAIT.
  - Go to WAIT.
- WAIT:
  - On division_finished_i, capture div_result_i and go to FIXUP.
  - division_finished_i arriving in IDLE or ISSUE is ignored.
- FIXUP (1 cycle):
  - Quotient is negated if the op is signed and the operand signs differ.
  - Remainder is negated if the op is signed and the dividend is negative.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU); go to DONE.
- DONE:
  - res_valid_o = 1; res_data_o and res_tag_o are held stable until res_ready_i.
  - On res_ready_i, return to IDLE; req_ready_o rises the next cycle.
  - No request is accepted while in DONE (no bypass).
- Divide by zero:
  - Quotient = all ones; remainder = rs1 unchanged.
  - Applies to both signed and unsigned ops.
  - No enable pulse; res_valid_o rises at N+1.
- Signed overflow:
  - Quotient = 0x80000000; remainder = 0.
  - No enable pulse; res_valid_o rises at N+1.
- Normal latency: res_valid_o at (cycle of division_finished_i) + 2.
- Magnitude of 0x80000000 is 0x80000000, taken as unsigned (two's-complement negate with wrap).
- flush_i:
  - In ISSUE or WAIT: set a drop flag. The FSM still waits for division_finished_i (the divider cannot abort), then goes to IDLE with no result.
  - In DONE: drop the result and go to IDLE next cycle.
  - In IDLE: no effect.
  - Simultaneous with req_valid_i in IDLE: the request is still accepted.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- When defined:
  - Keep one entry: rs1, rs2, signedness, quotient, remainder, valid bit.
  - The entry is written after FIXUP, even if the request was flushed.
  - A new request hits when rs1, rs2 and signedness match and the entry is valid; a DIV/REM pair counts as matching.
  - On a hit: go to DONE at N+1 with the selected field; no enable pulse.
  - The valid bit is cleared on reset.
- When undefined: no cache storage; every non-special request goes through the divider.

Decomposition:
- Package div_ctrl_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU);
  - div_state_t enum;
  - localparams SIGNED_MIN = 1 << (DATA_WIDTH-1) and ALL_ONES.
- Sub-module div_sign_fixup (combinational) takes the raw divider result, sign flags and op, and produces the final result.
  - It is reused for the cache hit path.

Test Plan:
- DIVU 100/7 -> res_data_o = 14; REMU 100/7 -> 2; exactly one div_enable_o pulse each; tags echoed.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; res_valid_o at N+1; div_enable_o never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; no divider activity.
- DIVU 1000/3 with res_ready_i held low for 3 cycles -> 333 stable and req_ready_o low throughout. Then flush_i during WAIT -> no res_valid_o; req_ready_o returns the cycle after division_finished_i + 1.
- With DIV_RESULT_CACHE_EN: DIV 1000/-3 -> 0xFFFFFEB3 (-333). Then REM 1000/-3 -> 1, valid at N+1, no enable pulse.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and constants for the divide issue/fixup stage
package div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = DIV_WIDTH'(1) << (DIV_WIDTH - 1);
  localparam logic [DIV_WIDTH-1:0] ALL_ONES   = '1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// rtl/div_sign_fixup.sv - applies sign correction to an unsigned {remainder, quotient}
// and selects the field the op asks for; shared by the divider and cache-hit paths.
module div_sign_fixup
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] raw,
  input  logic                    neg_dividend,
  input  logic                    neg_divisor,
  input  div_op_t                 op,
  output logic [DATA_WIDTH-1:0]   result
);

  logic [DATA_WIDTH-1:0] quot_raw;
  logic [DATA_WIDTH-1:0] rem_raw;
  logic [DATA_WIDTH-1:0] quot_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  assign quot_raw = raw[DATA_WIDTH-1:0];
  assign rem_raw  = raw[2*DATA_WIDTH-1:DATA_WIDTH];

  // Sign flags already fold in signedness, so unsigned ops never negate.
  assign quot_fix = (neg_dividend ^ neg_divisor) ? -quot_raw : quot_raw;
  assign rem_fix  = neg_dividend ? -rem_raw : rem_raw;

  assign result = op_is_rem(op) ? rem_fix : quot_fix;

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - RISC-V M divide issue/fixup stage in front of the iterative divider.
// Optional one-entry result cache enabled by DIV_RESULT_CACHE_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              op_i,
  input  logic [DATA_WIDTH-1:0]   rs1_i,
  input  logic [DATA_WIDTH-1:0]   rs2_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  input  logic                    flush_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [DATA_WIDTH-1:0]   res_data_o,
  output logic [TAG_WIDTH-1:0]    res_tag_o,
  output logic [DATA_WIDTH-1:0]   dividend_o,
  output logic [DATA_WIDTH-1:0]   divisor_o,
  output logic                    div_enable_o,
  input  logic                    division_finished_i,
  input  logic [2*DATA_WIDTH-1:0] div_result_i
);

  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONES    = '1;

  div_state_t              state;
  div_op_t                 op_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [DATA_WIDTH-1:0]   mag_a_q, mag_b_q, res_q;
  logic                    neg_a_q, neg_b_q, drop_q;
  logic [2*DATA_WIDTH-1:0] raw_q;

  div_op_t               op_in;
  logic                  in_signed, in_neg_a, in_neg_b;
  logic [DATA_WIDTH-1:0] in_mag_a, in_mag_b, special_res;
  logic                  accept, div_zero, overflow;

  assign op_in     = div_op_t'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign in_neg_a  = in_signed & rs1_i[DATA_WIDTH-1];
  assign in_neg_b  = in_signed & rs2_i[DATA_WIDTH-1];
  // Negating SIGNED_MIN wraps back to itself, which is its correct unsigned magnitude.
  assign in_mag_a  = in_neg_a ? -rs1_i : rs1_i;
  assign in_mag_b  = in_neg_b ? -rs2_i : rs2_i;
  assign accept    = req_valid_i && (state == ST_IDLE);
  assign div_zero  = (rs2_i == '0);
  assign overflow  = in_signed && (rs1_i == MIN_VAL) && (rs2_i == ONES);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_is_rem(op_in) ? rs1_i : ONES;
    else
      special_res = op_is_rem(op_in) ? '0 : MIN_VAL;
  end

  logic                    cache_hit;
  logic [2*DATA_WIDTH-1:0] cache_raw;

`ifdef DIV_RESULT_CACHE_EN
  logic                    c_valid, c_signed, p_signed;
  logic [DATA_WIDTH-1:0]   c_rs1, c_rs2, p_rs1, p_rs2;
  logic [2*DATA_WIDTH-1:0] c_raw;

  // Entry keeps the unsigned divider output; sign fixup is redone per request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid  <= 1'b0;
      c_signed <= 1'b0;
      c_rs1    <= '0;
      c_rs2    <= '0;
      c_raw    <= '0;
      p_signed <= 1'b0;
      p_rs1    <= '0;
      p_rs2    <= '0;
    end else begin
      if (accept) begin
        p_rs1    <= rs1_i;
        p_rs2    <= rs2_i;
        p_signed <= in_signed;
      end
      if (state == ST_FIXUP) begin
        c_valid  <= 1'b1;
        c_rs1    <= p_rs1;
        c_rs2    <= p_rs2;
        c_signed <= p_signed;
        c_raw    <= raw_q;
      end
    end
  end

  assign cache_hit = c_valid && (c_rs1 == rs1_i) && (c_rs2 == rs2_i) && (c_signed == in_signed);
  assign cache_raw = c_raw;
`else
  assign cache_hit = 1'b0;
  assign cache_raw = '0;
`endif

  logic [2*DATA_WIDTH-1:0] fix_raw;
  logic                    fix_neg_a, fix_neg_b;
  div_op_t                 fix_op;
  logic [DATA_WIDTH-1:0]   fix_result;

  // In IDLE the fixup unit serves the cache-hit path using the incoming request.
  assign fix_raw   = (state == ST_IDLE) ? cache_raw : raw_q;
  assign fix_neg_a = (state == ST_IDLE) ? in_neg_a  : neg_a_q;
  assign fix_neg_b = (state == ST_IDLE) ? in_neg_b  : neg_b_q;
  assign fix_op    = (state == ST_IDLE) ? op_in     : op_q;

  div_sign_fixup #(.DATA_WIDTH(DATA_WIDTH)) u_fixup (
    .raw          (fix_raw),
    .neg_dividend (fix_neg_a),
    .neg_divisor  (fix_neg_b),
    .op           (fix_op),
    .result       (fix_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_DIV;
      tag_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      res_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      drop_q  <= 1'b0;
      raw_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            tag_q   <= tag_i;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            mag_a_q <= in_mag_a;
            mag_b_q <= in_mag_b;
            drop_q  <= 1'b0;
            if (div_zero || overflow) begin
              res_q <= special_res;
              state <= ST_DONE;
            end else if (cache_hit) begin
              res_q <= fix_result;
              state <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (flush_i) drop_q <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush_i) drop_q <= 1'b1;
          if (division_finished_i) begin
            raw_q <= div_result_i;
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          res_q <= fix_result;
          state <= (drop_q || flush_i) ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          if (res_ready_i || flush_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic busy;
  assign busy         = (state == ST_ISSUE) || (state == ST_WAIT);
  assign req_ready_o  = (state == ST_IDLE);
  assign div_enable_o = (state == ST_ISSUE);
  assign dividend_o   = busy ? mag_a_q : '0;
  assign divisor_o    = busy ? mag_b_q : '0;
  assign res_valid_o  = (state == ST_DONE);
  assign res_data_o   = res_q;
  assign res_tag_o    = tag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl with a behavioural divider model;
// covers the DIV_RESULT_CACHE_EN build as well as the default build.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  tag_i = '0;
  logic        flush_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [31:0] res_data_o;
  logic [4:0]  res_tag_o;
  logic [31:0] dividend_o;
  logic [31:0] divisor_o;
  logic        div_enable_o;
  logic        division_finished_i = 1'b0;
  logic [63:0] div_result_i = '0;

  div_ctrl #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .op_i                (op_i),
    .rs1_i               (rs1_i),
    .rs2_i               (rs2_i),
    .tag_i               (tag_i),
    .flush_i             (flush_i),
    .res_valid_o         (res_valid_o),
    .res_ready_i         (res_ready_i),
    .res_data_o          (res_data_o),
    .res_tag_o           (res_tag_o),
    .dividend_o          (dividend_o),
    .divisor_o           (divisor_o),
    .div_enable_o        (div_enable_o),
    .division_finished_i (division_finished_i),
    .div_result_i        (div_result_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural unsigned divider: fixed latency after the enable pulse.
  int          en_count = 0;
  int          m_lat = 3;
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always @(posedge clk) begin
    division_finished_i <= 1'b0;
    if (div_enable_o) begin
      m_a      <= dividend_o;
      m_b      <= divisor_o;
      m_cnt    <= m_lat;
      m_busy   <= 1'b1;
      en_count <= en_count + 1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        division_finished_i <= 1'b1;
        div_result_i <= (m_b == 0) ? {m_a, 32'hFFFF_FFFF} : {m_a % m_b, m_a / m_b};
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } sb_item_t;
  sb_item_t sb_q[$];

  bit          ck_valid = 1'b0;
  bit          ck_s = 1'b0;
  logic [31:0] ck_a = '0;
  logic [31:0] ck_b = '0;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : ALL_ONES;
    if (!op[0] && a == SIGNED_MIN && b == ALL_ONES) return op[1] ? 32'h0 : SIGNED_MIN;
    case (op)
      2'b00:   return $unsigned(sa / sb);
      2'b01:   return a / b;
      2'b10:   return $unsigned(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit predict_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1'b1;
    if (!op[0] && a == SIGNED_MIN && b == ALL_ONES) return 1'b1;
    return CACHE && ck_valid && ck_a == a && ck_b == b && ck_s == !op[0];
  endfunction

  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int hold, input bit flush_accept, input string name);
    logic [31:0] exp_data;
    bit          fast;
    int          en0, acc_cyc, fin_cyc, n;
    sb_item_t    item;
    exp_data = ref_div(op, a, b);
    fast = predict_fast(op, a, b);
    sb_q.push_back('{data: exp_data, tag: tag});
    en0 = en_count;
    n = 0;
    while (!req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s req_ready got %b want 1", name, req_ready_o);
    end
    req_valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; tag_i = tag;
    flush_i = flush_accept; res_ready_i = (hold == 0);
    @(posedge clk); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    acc_cyc = cyc; fin_cyc = -1; n = 0;
    while (!res_valid_o && n < 300) begin
      if (division_finished_i) fin_cyc = cyc;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++; $display("FAIL %s timeout res_valid got %b want 1", name, res_valid_o);
      void'(sb_q.pop_front());
      res_ready_i = 1'b1;
      return;
    end
    if (fast) begin
      checks++;
      if (cyc != acc_cyc) begin
        errors++; $display("FAIL %s fast latency got %0d want 0 extra cycles", name, cyc - acc_cyc);
      end
      checks++;
      if (en_count != en0) begin
        errors++; $display("FAIL %s enable pulses got %0d want 0", name, en_count - en0);
      end
    end else begin
      checks++;
      if (fin_cyc < 0 || cyc - fin_cyc != 2) begin
        errors++; $display("FAIL %s latency after finish got %0d want 2", name, cyc - fin_cyc);
      end
      checks++;
      if (en_count - en0 != 1) begin
        errors++; $display("FAIL %s enable pulses got %0d want 1", name, en_count - en0);
      end
      ck_valid = 1'b1; ck_a = a; ck_b = b; ck_s = !op[0];
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (res_valid_o !== 1'b1 || res_data_o !== exp_data || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s hold valid=%b data=%h ready=%b want 1 %h 0", name, res_valid_o, res_data_o, req_ready_o, exp_data);
      end
      @(posedge clk); #1;
    end
    res_ready_i = 1'b1;
    item = sb_q.pop_front();
    checks++;
    if (res_data_o !== item.data) begin
      errors++; $display("FAIL %s data got %h want %h", name, res_data_o, item.data);
    end
    checks++;
    if (res_tag_o !== item.tag) begin
      errors++; $display("FAIL %s tag got %h want %h", name, res_tag_o, item.tag);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s release valid=%b ready=%b want 0 1", name, res_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0 || div_enable_o !== 1'b0 ||
        res_data_o !== 32'h0 || res_tag_o !== 5'h0 || dividend_o !== 32'h0 || divisor_o !== 32'h0) begin
      errors++;
      $display("FAIL reset ready=%b valid=%b en=%b data=%h tag=%h dvd=%h dvs=%h", req_ready_o, res_valid_o,
               div_enable_o, res_data_o, res_tag_o, dividend_o, divisor_o);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL post_reset ready=%b valid=%b want 1 0", req_ready_o, res_valid_o);
    end
  endtask

  task automatic test_unsigned();
    run_req(2'b01, 32'd100, 32'd7, 5'd1, 0, 1'b0, "divu_100_7");
    run_req(2'b11, 32'd100, 32'd7, 5'd2, 0, 1'b0, "remu_100_7");
  endtask

  task automatic test_signed();
    run_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 1'b0, "div_m7_2");
    run_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b0, "rem_m7_2");
    run_req(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd5, 0, 1'b0, "div_7_m2");
    run_req(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6, 0, 1'b0, "rem_7_m2");
    run_req(2'b01, SIGNED_MIN, 32'd2, 5'd7, 0, 1'b0, "divu_min_2");
  endtask

  task automatic test_special();
    run_req(2'b00, 32'd5, 32'd0, 5'd8, 0, 1'b0, "div_5_0");
    run_req(2'b11, 32'd5, 32'd0, 5'd9, 0, 1'b0, "remu_5_0");
    run_req(2'b00, SIGNED_MIN, ALL_ONES, 5'd10, 0, 1'b0, "div_ovf");
    run_req(2'b10, SIGNED_MIN, ALL_ONES, 5'd11, 0, 1'b0, "rem_ovf");
  endtask

  task automatic test_back_to_back();
    m_lat = 2;
    run_req(2'b01, 32'd1000, 32'd3, 5'd12, 3, 1'b0, "divu_hold");
    run_req(2'b01, 32'd77, 32'd5, 5'd13, 0, 1'b1, "flush_on_accept");
    m_lat = 3;
  endtask

  task automatic test_flush_wait();
    int en0, fin_cyc, n;
    bit saw_valid;
    en0 = en_count;
    req_valid_i = 1'b1; op_i = 2'b01; rs1_i = 32'd999; rs2_i = 32'd4; tag_i = 5'd14;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    fin_cyc = -1; saw_valid = 1'b0; n = 0;
    while (!req_ready_o && n < 300) begin
      if (division_finished_i) fin_cyc = cyc;
      if (res_valid_o) saw_valid = 1'b1;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (req_ready_o !== 1'b1 || fin_cyc < 0 || cyc - fin_cyc != 2) begin
      errors++; $display("FAIL flush_wait ready=%b return got %0d want 2", req_ready_o, cyc - fin_cyc);
    end
    checks++;
    if (saw_valid || res_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_wait res_valid seen got 1 want 0");
    end
    checks++;
    if (en_count - en0 != 1) begin
      errors++; $display("FAIL flush_wait pulses got %0d want 1", en_count - en0);
    end
    ck_valid = 1'b1; ck_a = 32'd999; ck_b = 32'd4; ck_s = 1'b0;
  endtask

  task automatic test_flush_done();
    res_ready_i = 1'b0;
    req_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd9; rs2_i = 32'd0; tag_i = 5'd15;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b1) begin
      errors++; $display("FAIL flush_done pre valid got %b want 1", res_valid_o);
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    res_ready_i = 1'b1;
    checks++;
    if (res_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_done valid=%b ready=%b want 0 1", res_valid_o, req_ready_o);
    end
  endtask

  task automatic test_cache();
    run_req(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd16, 0, 1'b0, "div_1000_m3");
    run_req(2'b10, 32'd1000, 32'hFFFF_FFFD, 5'd17, 0, 1'b0, "rem_1000_m3");
    run_req(2'b01, 32'd1000, 32'hFFFF_FFFD, 5'd18, 0, 1'b0, "divu_1000_m3");
  endtask

  task automatic test_async_reset();
    bit saw_valid;
    m_lat = 6;
    req_valid_i = 1'b1; op_i = 2'b01; rs1_i = 32'd50; rs2_i = 32'd5; tag_i = 5'd19;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || div_enable_o !== 1'b0 || dividend_o !== 32'h0 || res_tag_o !== 5'h0) begin
      errors++;
      $display("FAIL async_reset ready=%b en=%b dvd=%h tag=%h want 1 0 0 0", req_ready_o, div_enable_o, dividend_o, res_tag_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ck_valid = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (res_valid_o || !req_ready_o) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_valid) begin
      errors++; $display("FAIL stale_finish activity got 1 want 0");
    end
    m_lat = 3;
  endtask

  task automatic test_random();
    logic [31:0] edges [6];
    logic [31:0] a, b;
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = ALL_ONES;
    edges[3] = SIGNED_MIN; edges[4] = 32'h7FFF_FFFF; edges[5] = 32'd3;
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 5)] : ($urandom >> $urandom_range(0, 28));
      m_lat = $urandom_range(0, 5);
      run_req(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2), 1'b0, "random");
    end
    m_lat = 3;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_flush_wait();
    test_flush_done();
    test_cache();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
